// File: rtl/dc_val_cache.sv
// dc_val_cache
// Per-channel cache of the memory word each data channel (DC) points at.
// A sequential refill engine fetches a channel's word over a req/ack memory
// port whenever the channel is re-pointed, and every committed core store is
// snooped so that cached words stay coherent.
//
// Optional feature macro: DC_VAL_ACK_BYPASS_EN
//   defined   -> the ack cycle forwards mem_rdata straight to a reader of the
//                in-flight channel (no stall in that cycle)
//   undefined -> the reader stalls through the ack cycle
//
// Ports
//   clk, reset                 clock, synchronous active-low reset
//   dc_mutate/_idx/_addr       re-point one channel to a new address
//   wr_valid/wr_addr/wr_data   committed core store (snooped)
//   rd_en/rd_idx               operand read; rd_data/rd_stall combinational
//   mem_req/mem_addr           registered read request to data memory
//   mem_ack/mem_rdata          read completion
//   dc_vals/dc_valid           all cached words and their valid bits
//
// FSM states
//   state  | meaning
//   S_IDLE | no request outstanding; launches the lowest pending channel
//   S_WAIT | request outstanding; mem_req/mem_addr held until mem_ack
module dc_val_cache #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DC_COUNT   = 4,
    localparam int IDX_WIDTH = $clog2(DC_COUNT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dc_mutate,
    input  logic [IDX_WIDTH-1:0]           dc_mutate_idx,
    input  logic [ADDR_WIDTH-1:0]          dc_mutate_addr,
    input  logic                           wr_valid,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [WORD_WIDTH-1:0]          wr_data,
    input  logic                           rd_en,
    input  logic [IDX_WIDTH-1:0]           rd_idx,
    output logic [WORD_WIDTH-1:0]          rd_data,
    output logic                           rd_stall,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_ack,
    input  logic [WORD_WIDTH-1:0]          mem_rdata,
    output logic [DC_COUNT*WORD_WIDTH-1:0] dc_vals,
    output logic [DC_COUNT-1:0]            dc_valid
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q [DC_COUNT];
    logic [ADDR_WIDTH-1:0] addr_d [DC_COUNT];
    logic [WORD_WIDTH-1:0] val_q  [DC_COUNT];
    logic [WORD_WIDTH-1:0] val_d  [DC_COUNT];
    logic [DC_COUNT-1:0]   valid_q, valid_d;
    logic [DC_COUNT-1:0]   pending_q, pending_d;
    logic [IDX_WIDTH-1:0]  fetch_idx_q, fetch_idx_d;
    logic                  fetch_live_q, fetch_live_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic                  any_pending;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  launch;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        val_d        = val_q;
        valid_d      = valid_q;
        pending_d    = pending_q;
        fetch_idx_d  = fetch_idx_q;
        fetch_live_d = fetch_live_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        any_pending  = 1'b0;
        sel_idx      = '0;
        sel_addr     = '0;
        launch       = 1'b0;

        // Descending scan so the lowest pending index wins.
        for (int i = DC_COUNT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                any_pending = 1'b1;
                sel_idx     = IDX_WIDTH'(i);
                sel_addr    = addr_q[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (any_pending) begin
                    launch       = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_addr_d   = sel_addr;
                    fetch_idx_d  = sel_idx;
                    fetch_live_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    fetch_live_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < DC_COUNT; i++) begin
            if (state_q == S_WAIT && mem_ack && fetch_live_q &&
                fetch_idx_q == IDX_WIDTH'(i)) begin
                val_d[i]     = mem_rdata;
                valid_d[i]   = 1'b1;
                pending_d[i] = 1'b0;
            end

            // Mutate and snoop are applied after the engine write so they win
            // over a same-cycle ack; either one also kills the fetch targeting
            // this channel, whether already in flight or launching this cycle.
            if (dc_mutate && dc_mutate_idx == IDX_WIDTH'(i)) begin
                addr_d[i] = dc_mutate_addr;
                if (wr_valid && dc_mutate_addr == wr_addr) begin
                    val_d[i]     = wr_data;
                    valid_d[i]   = 1'b1;
                    pending_d[i] = 1'b0;
                end else begin
                    valid_d[i]   = 1'b0;
                    pending_d[i] = 1'b1;
                end
                if ((state_q == S_WAIT && fetch_idx_q == IDX_WIDTH'(i)) ||
                    (launch && sel_idx == IDX_WIDTH'(i))) begin
                    fetch_live_d = 1'b0;
                end
            end else if (wr_valid && (valid_q[i] || pending_q[i]) &&
                         addr_q[i] == wr_addr) begin
                val_d[i]     = wr_data;
                valid_d[i]   = 1'b1;
                pending_d[i] = 1'b0;
                if ((state_q == S_WAIT && fetch_idx_q == IDX_WIDTH'(i)) ||
                    (launch && sel_idx == IDX_WIDTH'(i))) begin
                    fetch_live_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '{default: '0};
            val_q        <= '{default: '0};
            valid_q      <= '0;
            pending_q    <= '0;
            fetch_idx_q  <= '0;
            fetch_live_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            val_q        <= val_d;
            valid_q      <= valid_d;
            pending_q    <= pending_d;
            fetch_idx_q  <= fetch_idx_d;
            fetch_live_q <= fetch_live_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Indices beyond DC_COUNT match no channel and read as 0 without stalling.
    always_comb begin
        rd_data  = '0;
        rd_stall = 1'b0;
        for (int i = 0; i < DC_COUNT; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) begin
                rd_data  = val_q[i];
                rd_stall = rd_en && !valid_q[i];
            end
        end
`ifdef DC_VAL_ACK_BYPASS_EN
        if (state_q == S_WAIT && mem_ack && fetch_live_q && rd_idx == fetch_idx_q) begin
            rd_data  = mem_rdata;
            rd_stall = 1'b0;
        end
`endif
    end

    always_comb begin
        dc_vals = '0;
        for (int i = 0; i < DC_COUNT; i++) begin
            dc_vals[i*WORD_WIDTH +: WORD_WIDTH] = val_q[i];
        end
    end

    assign dc_valid = valid_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_dc_val_cache.sv
module tb_dc_val_cache;

    logic         clk;
    logic         reset;
    logic         dc_mutate;
    logic [1:0]   dc_mutate_idx;
    logic [31:0]  dc_mutate_addr;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic         rd_en;
    logic [1:0]   rd_idx;
    logic [31:0]  rd_data;
    logic         rd_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic [127:0] dc_vals;
    logic [3:0]   dc_valid;

    int checks = 0;
    int errors = 0;

    dc_val_cache #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .DC_COUNT(4)) dut (
        .clk(clk), .reset(reset),
        .dc_mutate(dc_mutate), .dc_mutate_idx(dc_mutate_idx), .dc_mutate_addr(dc_mutate_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_stall(rd_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .dc_vals(dc_vals), .dc_valid(dc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mutate(input logic [1:0] idx, input logic [31:0] a);
        dc_mutate      = 1'b1;
        dc_mutate_idx  = idx;
        dc_mutate_addr = a;
    endtask

    initial begin
        reset = 1'b0; dc_mutate = 1'b0; dc_mutate_idx = '0; dc_mutate_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_idx = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b1;

        // reset state
        chk("rst_valid", dc_valid, 4'b0000);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_vals", dc_vals, 128'h0);
        rd_en = 1'b1; rd_idx = 2'd2; #1;
        chk("rst_stall2", rd_stall, 1'b1);
        rd_en = 1'b0;

        // basic fetch of channel 1
        mutate(2'd1, 32'h100);
        tick();
        dc_mutate = 1'b0;
        chk("f1_req_lat1", mem_req, 1'b0);
        tick();
        chk("f1_req", mem_req, 1'b1);
        chk("f1_addr", mem_addr, 32'h100);
        tick(); tick();
        chk("f1_req_hold", mem_req, 1'b1);
        chk("f1_addr_hold", mem_addr, 32'h100);
        rd_en = 1'b1; rd_idx = 2'd1;
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
`ifdef DC_VAL_ACK_BYPASS_EN
        chk("f1_byp_stall", rd_stall, 1'b0);
        chk("f1_byp_data", rd_data, 32'hDEADBEEF);
`else
        chk("f1_ack_stall", rd_stall, 1'b1);
`endif
        tick();
        mem_ack = 1'b0;
        chk("f1_req_drop", mem_req, 1'b0);
        chk("f1_valid", dc_valid, 4'b0010);
        chk("f1_val", dc_vals[63:32], 32'hDEADBEEF);
        chk("f1_stall_fall", rd_stall, 1'b0);
        chk("f1_rd_data", rd_data, 32'hDEADBEEF);
        rd_en = 1'b0;

        // two mutates on consecutive cycles: 0 first, then 3, IDLE gap
        mutate(2'd0, 32'h10);
        tick();
        mutate(2'd3, 32'h30);
        tick();
        dc_mutate = 1'b0;
        chk("seq_req0", mem_req, 1'b1);
        chk("seq_addr0", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'h1111;
        tick();
        mem_ack = 1'b0;
        chk("seq_gap", mem_req, 1'b0);
        tick();
        chk("seq_req3", mem_req, 1'b1);
        chk("seq_addr3", mem_addr, 32'h30);
        mem_ack = 1'b1; mem_rdata = 32'h3333;
        tick();
        mem_ack = 1'b0;
        chk("seq_valid", dc_valid, 4'b1011);
        chk("seq_val0", dc_vals[31:0], 32'h1111);
        chk("seq_val3", dc_vals[127:96], 32'h3333);

        // store snoop beats in-flight fetch of channel 2
        mutate(2'd2, 32'h200);
        tick();
        dc_mutate = 1'b0;
        tick();
        chk("sn_req", mem_req, 1'b1);
        chk("sn_addr", mem_addr, 32'h200);
        wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 32'h5;
        tick();
        wr_valid = 1'b0;
        chk("sn_val_early", dc_vals[95:64], 32'h5);
        chk("sn_req_hold", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h9;
        tick();
        mem_ack = 1'b0;
        chk("sn_val_kept", dc_vals[95:64], 32'h5);
        chk("sn_valid", dc_valid, 4'b1111);
        chk("sn_req_drop", mem_req, 1'b0);

        // remutate in flight: first response discarded, refetch at new addr
        mutate(2'd1, 32'h100);
        tick();
        dc_mutate = 1'b0;
        tick();
        chk("rm_req1", mem_req, 1'b1);
        chk("rm_addr1", mem_addr, 32'h100);
        mutate(2'd1, 32'h180);
        tick();
        dc_mutate = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD;
        tick();
        mem_ack = 1'b0;
        chk("rm_discard_val", dc_vals[63:32], 32'hDEADBEEF);
        chk("rm_discard_valid", dc_valid[1], 1'b0);
        chk("rm_gap", mem_req, 1'b0);
        tick();
        chk("rm_req2", mem_req, 1'b1);
        chk("rm_addr2", mem_addr, 32'h180);
        mem_ack = 1'b1; mem_rdata = 32'h18018;
        tick();
        mem_ack = 1'b0;
        chk("rm_val", dc_vals[63:32], 32'h18018);
        chk("rm_valid", dc_valid[1], 1'b1);

        // channels 1 and 3 both at 0x180, one store updates both
        mutate(2'd3, 32'h180);
        tick();
        dc_mutate = 1'b0;
        wr_valid = 1'b1; wr_addr = 32'h180; wr_data = 32'hABC;
        tick();
        wr_valid = 1'b0;
        chk("mm_val1", dc_vals[63:32], 32'hABC);
        chk("mm_val3", dc_vals[127:96], 32'hABC);
        chk("mm_valid", dc_valid, 4'b1111);
        chk("mm_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF;
        tick();
        mem_ack = 1'b0;
        chk("mm_val3_kept", dc_vals[127:96], 32'hABC);
        chk("mm_req_drop", mem_req, 1'b0);

        // mutate and store to the same new address: loads store data, no fetch
        mutate(2'd0, 32'h500);
        wr_valid = 1'b1; wr_addr = 32'h500; wr_data = 32'h55;
        tick();
        dc_mutate = 1'b0; wr_valid = 1'b0;
        chk("p1_val", dc_vals[31:0], 32'h55);
        chk("p1_valid", dc_valid[0], 1'b1);
        tick();
        chk("p1_nofetch", mem_req, 1'b0);

        // read during the ack cycle
        mutate(2'd1, 32'h700);
        tick();
        dc_mutate = 1'b0;
        tick();
        chk("by_addr", mem_addr, 32'h700);
        rd_en = 1'b1; rd_idx = 2'd1;
        mem_ack = 1'b1; mem_rdata = 32'h77; #1;
`ifdef DC_VAL_ACK_BYPASS_EN
        chk("by_stall", rd_stall, 1'b0);
        chk("by_data", rd_data, 32'h77);
`else
        chk("by_stall", rd_stall, 1'b1);
`endif
        tick();
        mem_ack = 1'b0;
        chk("by_after_stall", rd_stall, 1'b0);
        chk("by_after_data", rd_data, 32'h77);
        rd_en = 1'b0;

        // reset mid-fetch, late ack ignored
        mutate(2'd2, 32'h900);
        tick();
        dc_mutate = 1'b0;
        tick();
        chk("rr_req", mem_req, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rr_req0", mem_req, 1'b0);
        chk("rr_addr0", mem_addr, 32'h0);
        chk("rr_valid0", dc_valid, 4'b0000);
        mem_ack = 1'b1; mem_rdata = 32'h1234;
        tick();
        mem_ack = 1'b0;
        chk("rr_ack_ign_valid", dc_valid, 4'b0000);
        chk("rr_ack_ign_vals", dc_vals, 128'h0);
        tick();
        chk("rr_idle", mem_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
